// File: rtl/up_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : up_irq_ctrl
// Description : APB interrupt controller for user-plugin sources with W1C
//               pending bits, edge/level capture and a holdoff throttle.
// Revision    : 1.0 - initial release
// ============================================================================
module up_irq_ctrl #(
    parameter int N_SRC          = 3,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int HOLD_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_SRC-1:0]          src_i,
    output logic                      int_o
);

    localparam logic [2:0] c_OFF_PENDING = 3'd0;
    localparam logic [2:0] c_OFF_ENABLE  = 3'd1;
    localparam logic [2:0] c_OFF_MODE    = 3'd2;
    localparam logic [2:0] c_OFF_STATUS  = 3'd3;
    localparam logic [2:0] c_OFF_ID      = 3'd4;
    localparam logic [2:0] c_OFF_HOLDOFF = 3'd5;
    localparam logic [2:0] c_OFF_SET     = 3'd6;

    localparam logic [APB_ADDR_WIDTH-1:0] c_ADDR_LIMIT = APB_ADDR_WIDTH'(32'h1C);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ASSERT = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_enable;
    logic [N_SRC-1:0]  r_mode;
    logic [N_SRC-1:0]  r_src_q;
    logic [HOLD_W-1:0] r_holdoff;
    logic [HOLD_W-1:0] r_cnt;
    logic [1:0]        r_state;
    logic              r_int;

    logic              w_access;
    logic              w_addr_ok;
    logic              w_wr;
    logic [2:0]        w_off;
    logic [N_SRC-1:0]  w_w1c;
    logic [N_SRC-1:0]  w_set;
    logic [N_SRC-1:0]  w_hw_event;
    logic [N_SRC-1:0]  w_pending_nxt;
    logic [N_SRC-1:0]  w_status;
    logic              w_status_any;
    logic [3:0]        w_id_idx;
    logic [31:0]       w_rdata;
    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] w_cnt_nxt;

    // Only the low bits of the write data carry meaning.
    logic w_unused;
    assign w_unused = &{1'b0, PWDATA};

    assign w_access  = PSEL & PENABLE;
    assign w_addr_ok = (PADDR < c_ADDR_LIMIT);
    assign w_wr      = w_access & PWRITE & w_addr_ok;
    assign w_off     = PADDR[4:2];

    assign w_w1c = (w_wr && (w_off == c_OFF_PENDING)) ? PWDATA[N_SRC-1:0] : '0;
    assign w_set = (w_wr && (w_off == c_OFF_SET))     ? PWDATA[N_SRC-1:0] : '0;

    // Set/event terms are OR-ed after the clear so they win over a same-cycle W1C.
    assign w_hw_event    = (r_mode & src_i & ~r_src_q) | (~r_mode & src_i);
    assign w_pending_nxt = (r_pending & ~w_w1c) | w_hw_event | w_set;

    assign w_status     = r_pending & r_enable;
    assign w_status_any = |w_status;

    always_comb begin
        w_id_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_status[i]) begin
                w_id_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_addr_ok) begin
            case (w_off)
                c_OFF_PENDING: w_rdata[N_SRC-1:0]  = r_pending;
                c_OFF_ENABLE:  w_rdata[N_SRC-1:0]  = r_enable;
                c_OFF_MODE:    w_rdata[N_SRC-1:0]  = r_mode;
                c_OFF_STATUS:  w_rdata[N_SRC-1:0]  = w_status;
                c_OFF_ID: begin
                    w_rdata[31]  = w_status_any;
                    w_rdata[3:0] = w_id_idx;
                end
                c_OFF_HOLDOFF: w_rdata[HOLD_W-1:0] = r_holdoff;
                default:       w_rdata = '0;
            endcase
        end
    end

    assign PRDATA  = w_rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & ~w_addr_ok;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_mode    <= '0;
            r_src_q   <= '0;
            r_holdoff <= '0;
        end else begin
            r_src_q   <= src_i;
            r_pending <= w_pending_nxt;
            if (w_wr && (w_off == c_OFF_ENABLE))  r_enable  <= PWDATA[N_SRC-1:0];
            if (w_wr && (w_off == c_OFF_MODE))    r_mode    <= PWDATA[N_SRC-1:0];
            if (w_wr && (w_off == c_OFF_HOLDOFF)) r_holdoff <= PWDATA[HOLD_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_int   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_int   <= (w_state_nxt == c_ST_ASSERT);
        end
    end

    // The count is latched only on entry to HOLD, so HOLDOFF writes during HOLD wait for the next load.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_status_any) w_state_nxt = c_ST_ASSERT;
            end
            c_ST_ASSERT: begin
                if (!w_status_any) begin
                    if (r_holdoff == '0) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = r_holdoff;
                    end
                end
            end
            c_ST_HOLD: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= HOLD_W'(1)) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign int_o = r_int;

endmodule
`default_nettype wire

// File: tb/tb_up_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_irq_ctrl
// Description : Directed table-driven bench for up_irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [2:0]  src_i;
    logic        int_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    up_irq_ctrl #(.N_SRC(3), .APB_ADDR_WIDTH(12), .HOLD_W(16)) u_dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .src_i   (src_i),
        .int_o   (int_o)
    );

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        exp_int;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Two-phase write; returns at the falling edge just after the write edge.
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge clk_i);
        PENABLE = 1'b1;
        @(negedge clk_i);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk_i);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge clk_i);
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        check(name, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          low;
        bit          seen;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 12'h008, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 12'h00C, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 12'h010, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b0, 12'h014, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 12'h018, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b0, 12'h01C, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b1, 12'h014, 32'hFFFF_FFFF, 32'h0,       1'b0};
        vecs[9]  = '{1'b0, 12'h014, 32'h0,        32'h0000_FFFF, 1'b0};
        vecs[10] = '{1'b1, 12'h014, 32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 12'h008, 32'hFFFF_FFFF, 32'h0,       1'b0};
        vecs[12] = '{1'b0, 12'h008, 32'h0,        32'h7,        1'b0};
        vecs[13] = '{1'b1, 12'h004, 32'hFFFF_FFF8, 32'h0,       1'b0};
        vecs[14] = '{1'b0, 12'h004, 32'h0,        32'h0,        1'b0};
        vecs[15] = '{1'b1, 12'h018, 32'h3,        32'h0,        1'b0};
        vecs[16] = '{1'b0, 12'h000, 32'h0,        32'h3,        1'b0};
        vecs[17] = '{1'b0, 12'h00C, 32'h0,        32'h0,        1'b0};
        vecs[18] = '{1'b0, 12'h010, 32'h0,        32'h0,        1'b0};
        vecs[19] = '{1'b1, 12'h004, 32'h2,        32'h0,        1'b0};
        vecs[20] = '{1'b0, 12'h010, 32'h0,        32'h8000_0001, 1'b1};
        vecs[21] = '{1'b0, 12'h00C, 32'h0,        32'h2,        1'b1};
        vecs[22] = '{1'b1, 12'h000, 32'h3,        32'h0,        1'b0};
        vecs[23] = '{1'b0, 12'h000, 32'h0,        32'h0,        1'b0};

        rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; src_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_int", {31'b0, int_o}, 32'h0);
        check("pready", {31'b0, PREADY}, 32'h1);
        rst_n = 1'b1;

        // Register access table: reset values, masking, SET and STATUS/ID gating by ENABLE.
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, rd, err);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                check($sformatf("vec%0d_int", i), {31'b0, int_o}, {31'b0, vecs[i].exp_int});
            end
        end

        apb_read(12'h01C, rd, err);
        check("slverr_1c", {31'b0, err}, 32'h1);
        check("rdata_1c", rd, 32'h0);
        apb_read(12'h018, rd, err);
        check("slverr_18", {31'b0, err}, 32'h0);

        // Edge capture pulse on source 2 (MODE is all-edge from the table).
        apb_write(12'h004, 32'h7);
        @(negedge clk_i); src_i = 3'b100;
        @(negedge clk_i); src_i = 3'b000;
        check("edge_int_k", {31'b0, int_o}, 32'h0);
        @(negedge clk_i);
        check("edge_int_k1", {31'b0, int_o}, 32'h1);
        read_check("edge_pending", 12'h000, 32'h4);
        read_check("edge_id", 12'h010, 32'h8000_0002);
        apb_write(12'h000, 32'h4);
        check("edge_w1c_int_hold", {31'b0, int_o}, 32'h1);
        @(negedge clk_i);
        check("edge_w1c_int_drop", {31'b0, int_o}, 32'h0);

        // Level mode: clear is ignored while the line is still high.
        apb_write(12'h008, 32'h0);
        apb_write(12'h004, 32'h1);
        @(negedge clk_i); src_i = 3'b001;
        @(negedge clk_i);
        @(negedge clk_i);
        check("level_int", {31'b0, int_o}, 32'h1);
        apb_write(12'h000, 32'h1);
        read_check("level_w1c_high", 12'h000, 32'h1);
        check("level_int_stays", {31'b0, int_o}, 32'h1);
        @(negedge clk_i); src_i = 3'b000;
        @(negedge clk_i);
        apb_write(12'h000, 32'h1);
        check("level_clr_int_hold", {31'b0, int_o}, 32'h1);
        @(negedge clk_i);
        check("level_clr_int_drop", {31'b0, int_o}, 32'h0);
        read_check("level_pending", 12'h000, 32'h0);

        // Holdoff: 5 HOLD cycles plus one IDLE; mid-HOLD HOLDOFF write must not shorten it.
        apb_write(12'h008, 32'h7);
        apb_write(12'h004, 32'h7);
        apb_write(12'h014, 32'h5);
        @(negedge clk_i); src_i = 3'b010;
        @(negedge clk_i); src_i = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (int_o) begin seen = 1'b1; break; end
            @(negedge clk_i);
        end
        check("hold_first_assert", {31'b0, seen}, 32'h1);
        apb_write(12'h000, 32'h2);
        check("hold_int_before_drop", {31'b0, int_o}, 32'h1);
        low = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            if (i == 1) src_i = 3'b010;
            if (i == 2) begin
                src_i = 3'b000;
                PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 12'h014; PWDATA = 32'h1;
            end
            if (i == 3) PENABLE = 1'b1;
            if (i == 4) begin PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; end
            if (int_o) begin seen = 1'b1; break; end
            low++;
        end
        check("hold_reassert", {31'b0, seen}, 32'h1);
        check("hold_low_cycles", low, 32'd6);
        read_check("hold_pending", 12'h000, 32'h2);
        read_check("hold_holdoff_new", 12'h014, 32'h1);
        apb_write(12'h014, 32'h0);
        apb_write(12'h000, 32'h2);
        @(negedge clk_i);
        check("hold_cleanup_int", {31'b0, int_o}, 32'h0);

        // Same-cycle W1C and rising edge on source 0: the event wins.
        apb_write(12'h004, 32'h1);
        apb_write(12'h018, 32'h1);
        @(negedge clk_i);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 12'h000; PWDATA = 32'h1;
        @(negedge clk_i);
        PENABLE = 1'b1; src_i = 3'b001;
        @(negedge clk_i);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        read_check("race_pending", 12'h000, 32'h1);
        check("race_int", {31'b0, int_o}, 32'h1);

        // Asynchronous reset while asserting.
        @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("rst_int_async", {31'b0, int_o}, 32'h0);
        src_i = 3'b000;
        read_check("rst_pending", 12'h000, 32'h0);
        read_check("rst_enable", 12'h004, 32'h0);
        read_check("rst_mode", 12'h008, 32'h0);
        read_check("rst_holdoff", 12'h014, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_int", {31'b0, int_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
